// File: rtl/excess3_serial_decoder.sv
// Serial Excess-3 to BCD decoder: assembles LSB-first 4-bit codes, decodes them
// and queues {bcd, err} in a small output FIFO with drop-on-full and status counters.
module excess3_serial_decoder #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       bit_in,
    input  logic       bit_valid,
    input  logic       clr,
    output logic [3:0] bcd_out,
    output logic       err_out,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       overflow,
    output logic [7:0] digit_count,
    output logic [7:0] err_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [1:0]    bit_cnt;
    logic [3:0]    shreg;
    logic [4:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   fifo_cnt;

    logic       sample;
    logic       complete;
    logic [3:0] code;
    logic [3:0] dec_bcd;
    logic       dec_err;
    logic       full;
    logic       pop;
    logic       push;
    logic       drop;

    assign sample   = bit_valid && !clr;
    assign complete = sample && (bit_cnt == 2'd3);
    // The final bit goes straight into the decode so the push happens this cycle.
    assign code     = {bit_in, shreg[2:0]};

    always_comb begin
        dec_bcd = 4'hF;
        dec_err = 1'b1;
        if (code >= 4'd3 && code <= 4'd12) begin
            dec_bcd = code - 4'd3;
            dec_err = 1'b0;
        end
    end

    assign out_valid = (fifo_cnt != '0);
    assign full      = (fifo_cnt == FULL_CNT);
    assign pop       = out_valid && out_ready;
    // A full FIFO still takes the new digit when the head leaves in the same cycle.
    assign push      = complete && (!full || pop);
    assign drop      = complete && full && !pop;

    assign bcd_out = out_valid ? mem[rd_ptr][4:1] : 4'h0;
    assign err_out = out_valid ? mem[rd_ptr][0]   : 1'b0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt     <= 2'd0;
            shreg       <= 4'h0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_cnt    <= '0;
            overflow    <= 1'b0;
            digit_count <= 8'd0;
            err_count   <= 8'd0;
        end else begin
            if (clr) begin
                bit_cnt <= 2'd0;
                shreg   <= 4'h0;
            end else if (sample) begin
                shreg[bit_cnt] <= bit_in;
                bit_cnt        <= bit_cnt + 2'd1;
            end

            if (push) begin
                mem[wr_ptr] <= {dec_bcd, dec_err};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                fifo_cnt <= fifo_cnt + 1'b1;
            end else if (pop && !push) begin
                fifo_cnt <= fifo_cnt - 1'b1;
            end

            if (drop) begin
                overflow <= 1'b1;
            end
            if (complete) begin
                digit_count <= digit_count + 8'd1;
                if (dec_err && err_count != 8'hFF) begin
                    err_count <= err_count + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_excess3_serial_decoder.sv
// Directed bench for excess3_serial_decoder: a 16-code decode table plus
// hand-written sequences for FIFO full/overflow, clr, reset mid-digit and saturation.
module tb_excess3_serial_decoder;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       bit_in;
    logic       bit_valid;
    logic       clr;
    logic       out_ready;
    logic [3:0] bcd_out;
    logic       err_out;
    logic       out_valid;
    logic       overflow;
    logic [7:0] digit_count;
    logic [7:0] err_count;

    int checks   = 0;
    int failures = 0;

    int exp_digits;
    int exp_errs;

    typedef struct {
        logic [3:0] code;
        logic [3:0] bcd;
        logic       err;
    } vec_t;

    vec_t vecs [16];

    excess3_serial_decoder #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bit_in      (bit_in),
        .bit_valid   (bit_valid),
        .clr         (clr),
        .bcd_out     (bcd_out),
        .err_out     (err_out),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .overflow    (overflow),
        .digit_count (digit_count),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Inputs change and outputs are checked on the falling edge.
    task automatic send_digit(input logic [3:0] code, input bit pop_last);
        for (int i = 0; i < 4; i++) begin
            bit_valid = 1'b1;
            bit_in    = code[i];
            out_ready = pop_last && (i == 3);
            @(negedge clk);
        end
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic send_bits2(input logic b0, input logic b1);
        bit_valid = 1'b1;
        bit_in    = b0;
        @(negedge clk);
        bit_in    = b1;
        @(negedge clk);
        bit_valid = 1'b0;
        bit_in    = 1'b0;
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_digits = 0;
        exp_errs   = 0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_out_valid"},   int'(out_valid),   0);
        chk({tag, "_bcd_out"},     int'(bcd_out),     0);
        chk({tag, "_err_out"},     int'(err_out),     0);
        chk({tag, "_overflow"},    int'(overflow),    0);
        chk({tag, "_digit_count"}, int'(digit_count), 0);
        chk({tag, "_err_count"},   int'(err_count),   0);
    endtask

    initial begin
        vecs[0]  = '{4'b0000, 4'hF, 1'b1};
        vecs[1]  = '{4'b0001, 4'hF, 1'b1};
        vecs[2]  = '{4'b0010, 4'hF, 1'b1};
        vecs[3]  = '{4'b0011, 4'd0, 1'b0};
        vecs[4]  = '{4'b0100, 4'd1, 1'b0};
        vecs[5]  = '{4'b0101, 4'd2, 1'b0};
        vecs[6]  = '{4'b0110, 4'd3, 1'b0};
        vecs[7]  = '{4'b0111, 4'd4, 1'b0};
        vecs[8]  = '{4'b1000, 4'd5, 1'b0};
        vecs[9]  = '{4'b1001, 4'd6, 1'b0};
        vecs[10] = '{4'b1010, 4'd7, 1'b0};
        vecs[11] = '{4'b1011, 4'd8, 1'b0};
        vecs[12] = '{4'b1100, 4'd9, 1'b0};
        vecs[13] = '{4'b1101, 4'hF, 1'b1};
        vecs[14] = '{4'b1110, 4'hF, 1'b1};
        vecs[15] = '{4'b1111, 4'hF, 1'b1};

        rst_n     = 1'b0;
        bit_in    = 1'b1;
        bit_valid = 1'b1;
        clr       = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk_reset_state("rst");
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        out_ready = 1'b0;
        do_reset();

        // First digit: code 0011 sent as bits 1,1,0,0.
        send_digit(4'b0011, 1'b0);
        exp_digits++;
        chk("first_out_valid",   int'(out_valid),   1);
        chk("first_bcd",         int'(bcd_out),     0);
        chk("first_err",         int'(err_out),     0);
        chk("first_digit_count", int'(digit_count), exp_digits);
        pop_one();

        // Full decode table; the head is held one extra cycle with out_ready=0.
        for (int v = 0; v < 16; v++) begin
            send_digit(vecs[v].code, 1'b0);
            exp_digits++;
            if (vecs[v].err) exp_errs++;
            @(negedge clk);
            chk($sformatf("tbl%0d_valid", v), int'(out_valid), 1);
            chk($sformatf("tbl%0d_bcd", v),   int'(bcd_out),   int'(vecs[v].bcd));
            chk($sformatf("tbl%0d_err", v),   int'(err_out),   int'(vecs[v].err));
            pop_one();
            chk($sformatf("tbl%0d_empty_valid", v), int'(out_valid), 0);
            chk($sformatf("tbl%0d_empty_bcd", v),   int'(bcd_out),   0);
        end
        chk("tbl_digit_count", int'(digit_count), exp_digits);
        chk("tbl_err_count",   int'(err_count),   exp_errs);

        // Two queued invalid codes.
        do_reset();
        send_digit(4'b1111, 1'b0);
        send_digit(4'b0000, 1'b0);
        chk("inv1_bcd", int'(bcd_out), 15);
        chk("inv1_err", int'(err_out), 1);
        pop_one();
        chk("inv2_bcd", int'(bcd_out), 15);
        chk("inv2_err", int'(err_out), 1);
        pop_one();
        chk("inv_empty",     int'(out_valid), 0);
        chk("inv_err_count", int'(err_count), 2);

        // DEPTH+1 digits with no consumer: the last one is dropped.
        do_reset();
        for (int k = 0; k <= DEPTH; k++) begin
            send_digit(4'(k + 3), 1'b0);
        end
        chk("ovf_flag",        int'(overflow),    1);
        chk("ovf_digit_count", int'(digit_count), DEPTH + 1);
        out_ready = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            chk($sformatf("ovf_drain%0d_valid", k), int'(out_valid), 1);
            chk($sformatf("ovf_drain%0d_bcd", k),   int'(bcd_out),   k);
            @(negedge clk);
        end
        out_ready = 1'b0;
        chk("ovf_drained_valid", int'(out_valid), 0);
        chk("ovf_sticky",        int'(overflow),  1);

        // Full FIFO with a pop in the completing cycle: push accepted, order kept.
        do_reset();
        for (int k = 0; k < DEPTH; k++) begin
            send_digit(4'(k + 3), 1'b0);
        end
        send_digit(4'b1010, 1'b1);
        chk("pp_overflow", int'(overflow), 0);
        out_ready = 1'b1;
        for (int k = 1; k <= DEPTH; k++) begin
            chk($sformatf("pp_drain%0d_valid", k), int'(out_valid), 1);
            chk($sformatf("pp_drain%0d_bcd", k),   int'(bcd_out),   (k == DEPTH) ? 7 : k);
            @(negedge clk);
        end
        out_ready = 1'b0;
        chk("pp_empty", int'(out_valid), 0);

        // clr mid-digit, with bit_valid asserted in the same cycle.
        do_reset();
        send_bits2(1'b1, 1'b0);
        clr       = 1'b1;
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        @(negedge clk);
        clr       = 1'b0;
        bit_valid = 1'b0;
        chk("clr_no_entry", int'(out_valid), 0);
        send_digit(4'b0111, 1'b0);
        chk("clr_valid",       int'(out_valid),   1);
        chk("clr_bcd",         int'(bcd_out),     4);
        chk("clr_digit_count", int'(digit_count), 1);
        pop_one();
        chk("clr_single", int'(out_valid), 0);

        // Reset arriving mid-digit with the FIFO full.
        for (int k = 0; k < DEPTH; k++) begin
            send_digit(4'b0100, 1'b0);
        end
        send_bits2(1'b1, 1'b1);
        rst_n     = 1'b0;
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        out_ready = 1'b1;
        clr       = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        bit_valid = 1'b0;
        out_ready = 1'b0;
        chk_reset_state("midrst");
        send_digit(4'b1000, 1'b0);
        chk("midrst_valid", int'(out_valid),   1);
        chk("midrst_bcd",   int'(bcd_out),     5);
        chk("midrst_count", int'(digit_count), 1);
        pop_one();
        chk("midrst_single", int'(out_valid), 0);

        // err_count saturates while digit_count wraps.
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 256; k++) begin
            bit_valid = 1'b1;
            for (int b = 0; b < 4; b++) begin
                bit_in = 1'b1;
                @(negedge clk);
            end
        end
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        chk("sat_err_count",   int'(err_count),   255);
        chk("sat_digit_count", int'(digit_count), 0);
        chk("sat_overflow",    int'(overflow),    0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
